e203_exu_wbck_arb: RTL and testbench

Writeback arbiter and long-pipe scoreboard for the integer register file's single write port. It merges the single-cycle ALU writeback stream and the long-pipe (LSU/MulDiv) writeback stream onto one write port, using long-pipe priority with a bounded starvation guard for the ALU. It also tracks in-flight long-pipe destinations so dispatch can detect RAW and WAW hazards. It sits between the EXU dispatch/ALU/long-pipe units and the register file.

---
 rtl/e203_exu_wbck_arb_if.sv | 57 +++++
 rtl/e203_exu_wbck_arb.sv | 122 ++++++++++++
 tb/tb_e203_exu_wbck_arb.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/e203_exu_wbck_arb_if.sv
// Writeback, long-pipe dispatch, hazard-check and register-file write signals
// shared by the writeback arbiter and its neighbours.
interface e203_exu_wbck_arb_if #(
  parameter int unsigned RFIDX_W = 5,
  parameter int unsigned XLEN    = 32
);
  logic               alu_wbck_valid;
  logic               alu_wbck_ready;
  logic [RFIDX_W-1:0] alu_wbck_idx;
  logic [XLEN-1:0]    alu_wbck_dat;

  logic               longp_wbck_valid;
  logic               longp_wbck_ready;
  logic               longp_wbck_wen;
  logic [RFIDX_W-1:0] longp_wbck_idx;
  logic [XLEN-1:0]    longp_wbck_dat;

  logic               disp_longp_valid;
  logic               disp_longp_ready;
  logic               disp_longp_rdwen;
  logic [RFIDX_W-1:0] disp_longp_idx;

  logic [RFIDX_W-1:0] chk_src1_idx;
  logic [RFIDX_W-1:0] chk_src2_idx;
  logic [RFIDX_W-1:0] chk_dest_idx;
  logic               chk_src1_dep;
  logic               chk_src2_dep;
  logic               chk_waw_dep;

  logic               rf_wen;
  logic [RFIDX_W-1:0] rf_widx;
  logic [XLEN-1:0]    rf_wdat;

  logic               oitf_empty;

  // Requesters and the register file side.
  modport master (
    output alu_wbck_valid, alu_wbck_idx, alu_wbck_dat,
    output longp_wbck_valid, longp_wbck_wen, longp_wbck_idx, longp_wbck_dat,
    output disp_longp_valid, disp_longp_rdwen, disp_longp_idx,
    output chk_src1_idx, chk_src2_idx, chk_dest_idx,
    input  alu_wbck_ready, longp_wbck_ready, disp_longp_ready,
    input  chk_src1_dep, chk_src2_dep, chk_waw_dep,
    input  rf_wen, rf_widx, rf_wdat, oitf_empty
  );

  // The arbiter itself.
  modport slave (
    input  alu_wbck_valid, alu_wbck_idx, alu_wbck_dat,
    input  longp_wbck_valid, longp_wbck_wen, longp_wbck_idx, longp_wbck_dat,
    input  disp_longp_valid, disp_longp_rdwen, disp_longp_idx,
    input  chk_src1_idx, chk_src2_idx, chk_dest_idx,
    output alu_wbck_ready, longp_wbck_ready, disp_longp_ready,
    output chk_src1_dep, chk_src2_dep, chk_waw_dep,
    output rf_wen, rf_widx, rf_wdat, oitf_empty
  );
endinterface

// File: rtl/e203_exu_wbck_arb.sv
// Register-file write-port arbiter (long pipe first, ALU starvation guard)
// plus the outstanding long-pipe destination scoreboard.
module e203_exu_wbck_arb #(
  parameter int unsigned RFIDX_W    = 5,
  parameter int unsigned XLEN       = 32,
  parameter int unsigned RFREG_NUM  = 32,
  parameter int unsigned OUT_DEPTH  = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  e203_exu_wbck_arb_if.slave   bus
);

  localparam int unsigned CNT_W = $clog2(OUT_DEPTH + 1);
  localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);

  logic [RFREG_NUM-1:0] pend;
  logic [RFREG_NUM-1:0] pend_nxt;
  logic [CNT_W-1:0]     out_cnt;
  logic [CNT_W-1:0]     out_cnt_nxt;
  logic [STV_W-1:0]     starve_cnt;
  logic [STV_W-1:0]     starve_nxt;

  logic               longp_req;
  logic               force_alu;
  logic               longp_gnt;
  logic               alu_gnt;
  logic               longp_hs;
  logic               disp_hs;
  logic [RFIDX_W-1:0] alu_idx;
  logic [RFIDX_W-1:0] longp_idx;
  logic [XLEN-1:0]    alu_dat;
  logic [XLEN-1:0]    longp_dat;

  assign alu_idx   = bus.alu_wbck_idx;
  assign longp_idx = bus.longp_wbck_idx;
  assign alu_dat   = bus.alu_wbck_dat;
  assign longp_dat = bus.longp_wbck_dat;

  // Grant: long pipe wins unless the ALU has waited STARVE_MAX grants.
  always_comb begin
    longp_req = bus.longp_wbck_valid & bus.longp_wbck_wen;
    force_alu = (starve_cnt == STV_W'(STARVE_MAX));
    longp_gnt = longp_req & ~force_alu;
    alu_gnt   = bus.alu_wbck_valid & ~longp_gnt;
    longp_hs  = bus.longp_wbck_valid & (~bus.longp_wbck_wen | longp_gnt);
    disp_hs   = bus.disp_longp_valid & (out_cnt < CNT_W'(OUT_DEPTH));
  end

  // Handshake, write-port and status outputs.
  always_comb begin
    bus.alu_wbck_ready   = alu_gnt;
    bus.longp_wbck_ready = ~bus.longp_wbck_wen | longp_gnt;
    bus.disp_longp_ready = (out_cnt < CNT_W'(OUT_DEPTH));
    bus.oitf_empty       = (out_cnt == '0);
    bus.rf_wen           = 1'b0;
    bus.rf_widx          = '0;
    bus.rf_wdat          = '0;
    if (longp_gnt) begin
      bus.rf_wen  = (longp_idx != '0);
      bus.rf_widx = longp_idx;
      bus.rf_wdat = longp_dat;
    end else if (alu_gnt) begin
      bus.rf_wen  = (alu_idx != '0);
      bus.rf_widx = alu_idx;
      bus.rf_wdat = alu_dat;
    end
    bus.chk_src1_dep = pend[bus.chk_src1_idx];
    bus.chk_src2_dep = pend[bus.chk_src2_idx];
    bus.chk_waw_dep  = pend[bus.chk_dest_idx];
  end

  // Next-state: a same-cycle set of an index overrides its clear.
  always_comb begin
    pend_nxt = pend;
    if (longp_hs && bus.longp_wbck_wen) begin
      pend_nxt[longp_idx] = 1'b0;
    end
    if (disp_hs && bus.disp_longp_rdwen) begin
      pend_nxt[bus.disp_longp_idx] = 1'b1;
    end
    pend_nxt[0] = 1'b0;

    out_cnt_nxt = out_cnt;
    if (disp_hs && !longp_hs) begin
      out_cnt_nxt = out_cnt + CNT_W'(1);
    end else if (!disp_hs && longp_hs) begin
      out_cnt_nxt = out_cnt - CNT_W'(1);
    end

    starve_nxt = starve_cnt;
    if (!bus.alu_wbck_valid || alu_gnt) begin
      starve_nxt = '0;
    end else if (longp_gnt && !force_alu) begin
      starve_nxt = starve_cnt + STV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend       <= '0;
      out_cnt    <= '0;
      starve_cnt <= '0;
    end else begin
      pend       <= pend_nxt;
      out_cnt    <= out_cnt_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  // Protocol violations by the surrounding pipeline; no recovery is attempted.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(bus.longp_wbck_valid && out_cnt == '0));
      assert (!(disp_hs && bus.disp_longp_rdwen && bus.disp_longp_idx != '0 &&
                pend[bus.disp_longp_idx] &&
                !(longp_hs && bus.longp_wbck_wen && longp_idx == bus.disp_longp_idx)));
    end
  end

endmodule

// File: tb/tb_e203_exu_wbck_arb.sv
// Directed plus randomized bench for e203_exu_wbck_arb against an in-order
// queue model of the outstanding long-pipe operations.
module tb_e203_exu_wbck_arb;

  localparam int unsigned OUT_DEPTH  = 2;
  localparam int unsigned STARVE_MAX = 4;

  typedef struct packed {
    logic [4:0] idx;
    logic       rdwen;
  } op_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  e203_exu_wbck_arb_if #(.RFIDX_W(5), .XLEN(32)) bus ();

  e203_exu_wbck_arb #(
    .RFIDX_W(5), .XLEN(32), .RFREG_NUM(32),
    .OUT_DEPTH(OUT_DEPTH), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  op_t q[$];
  int  starve_m;
  int  vectors;
  int  miscompares;
  bit  alu_busy, lp_busy, disp_busy;
  bit  m_ag, m_lg, m_lp_hs, m_disp_hs;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit pend_m(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    foreach (q[i]) if (q[i].rdwen && q[i].idx == r) return 1'b1;
    return 1'b0;
  endfunction

  // Compare every output against the model at the falling edge.
  task automatic sample();
    bit          wen;
    logic [4:0]  widx;
    logic [31:0] wdat;
    @(negedge clk);
    m_lg      = bus.longp_wbck_valid && bus.longp_wbck_wen && (starve_m < int'(STARVE_MAX));
    m_ag      = bus.alu_wbck_valid && !m_lg;
    m_lp_hs   = bus.longp_wbck_valid && (!bus.longp_wbck_wen || m_lg);
    m_disp_hs = bus.disp_longp_valid && (q.size() < int'(OUT_DEPTH));
    wen = 1'b0; widx = '0; wdat = '0;
    if (m_lg) begin
      widx = bus.longp_wbck_idx; wdat = bus.longp_wbck_dat; wen = (widx != 5'd0);
    end else if (m_ag) begin
      widx = bus.alu_wbck_idx; wdat = bus.alu_wbck_dat; wen = (widx != 5'd0);
    end
    chk("alu_ready",   32'(bus.alu_wbck_ready),   32'(m_ag));
    chk("longp_ready", 32'(bus.longp_wbck_ready), 32'(!bus.longp_wbck_wen || m_lg));
    chk("disp_ready",  32'(bus.disp_longp_ready), 32'(q.size() < int'(OUT_DEPTH)));
    chk("oitf_empty",  32'(bus.oitf_empty),       32'(q.size() == 0));
    chk("rf_wen",      32'(bus.rf_wen),           32'(wen));
    chk("rf_widx",     32'(bus.rf_widx),          32'(widx));
    chk("rf_wdat",     bus.rf_wdat,               wdat);
    chk("src1_dep",    32'(bus.chk_src1_dep),     32'(pend_m(bus.chk_src1_idx)));
    chk("src2_dep",    32'(bus.chk_src2_dep),     32'(pend_m(bus.chk_src2_idx)));
    chk("waw_dep",     32'(bus.chk_waw_dep),      32'(pend_m(bus.chk_dest_idx)));
  endtask

  // Retire the cycle in the model on the rising edge.
  task automatic advance();
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      starve_m  = 0;
      alu_busy  = 1'b0;
      lp_busy   = 1'b0;
      disp_busy = 1'b0;
    end else begin
      if (m_lp_hs) void'(q.pop_front());
      if (m_disp_hs) q.push_back('{idx: bus.disp_longp_idx, rdwen: bus.disp_longp_rdwen});
      if (bus.alu_wbck_valid && !m_ag)
        starve_m = (starve_m < int'(STARVE_MAX)) ? starve_m + 1 : int'(STARVE_MAX);
      else
        starve_m = 0;
      if (m_ag) alu_busy = 1'b0;
      if (m_lp_hs) lp_busy = 1'b0;
      if (m_disp_hs) disp_busy = 1'b0;
    end
    #1;
  endtask

  task automatic idle();
    bus.alu_wbck_valid = 1'b0; bus.alu_wbck_idx = '0; bus.alu_wbck_dat = '0;
    bus.longp_wbck_valid = 1'b0; bus.longp_wbck_wen = 1'b0;
    bus.longp_wbck_idx = '0; bus.longp_wbck_dat = '0;
    bus.disp_longp_valid = 1'b0; bus.disp_longp_rdwen = 1'b0; bus.disp_longp_idx = '0;
    bus.chk_src1_idx = '0; bus.chk_src2_idx = '0; bus.chk_dest_idx = '0;
    alu_busy = 1'b0; lp_busy = 1'b0; disp_busy = 1'b0;
  endtask

  task automatic set_alu(input bit v, input logic [4:0] idx, input logic [31:0] dat);
    bus.alu_wbck_valid = v; bus.alu_wbck_idx = idx; bus.alu_wbck_dat = dat;
  endtask

  task automatic set_lp(input bit v, input bit wen, input logic [4:0] idx, input logic [31:0] dat);
    bus.longp_wbck_valid = v; bus.longp_wbck_wen = wen;
    bus.longp_wbck_idx = idx; bus.longp_wbck_dat = dat;
  endtask

  task automatic set_disp(input bit v, input bit rdwen, input logic [4:0] idx);
    bus.disp_longp_valid = v; bus.disp_longp_rdwen = rdwen; bus.disp_longp_idx = idx;
  endtask

  // Legal random requesters: held until accepted, completions in dispatch order.
  task automatic drive(input int p_alu, input int p_lp, input int p_disp, input int p_wen);
    logic [4:0] idx;
    if (!alu_busy) begin
      set_alu($urandom_range(99, 0) < p_alu, 5'($urandom_range(31, 0)), $urandom());
      alu_busy = bus.alu_wbck_valid;
    end
    if (!lp_busy) begin
      if (q.size() > 0 && $urandom_range(99, 0) < p_lp) begin
        set_lp(1'b1, q[0].rdwen, q[0].idx, $urandom());
        lp_busy = 1'b1;
      end else begin
        set_lp(1'b0, 1'($urandom_range(1, 0)), 5'($urandom_range(31, 0)), $urandom());
      end
    end
    if (!disp_busy) begin
      if ($urandom_range(99, 0) < p_disp) begin
        idx = 5'($urandom_range(31, 1));
        for (int t = 0; t < 64 && pend_m(idx); t++) idx = 5'($urandom_range(31, 1));
        set_disp(1'b1, ($urandom_range(99, 0) < p_wen) && !pend_m(idx), idx);
        disp_busy = 1'b1;
      end else begin
        set_disp(1'b0, 1'b0, '0);
      end
    end
    bus.chk_src1_idx = 5'($urandom_range(31, 0));
    bus.chk_src2_idx = 5'($urandom_range(31, 0));
    bus.chk_dest_idx = 5'($urandom_range(31, 0));
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (q.size() != 0 || alu_busy || lp_busy || disp_busy); i++) begin
      drive(0, 100, 0, 0);
      sample();
      advance();
    end
    chk("drain_empty", 32'(q.size()), 32'd0);
    idle();
  endtask

  initial begin
    vectors = 0; miscompares = 0; starve_m = 0;
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    q.delete();
    rst_n = 1'b1;

    // Idle after reset, stable for three cycles.
    for (int k = 0; k < 3; k++) begin
      sample();
      chk("rst_oitf_empty", 32'(bus.oitf_empty), 32'd1);
      chk("rst_disp_ready", 32'(bus.disp_longp_ready), 32'd1);
      chk("rst_rf_wen",     32'(bus.rf_wen), 32'd0);
      chk("rst_src1_dep",   32'(bus.chk_src1_dep), 32'd0);
      advance();
    end

    // Dispatch rd=5, see the RAW dependence, then complete it.
    set_disp(1'b1, 1'b1, 5'd5);
    sample(); advance();
    set_disp(1'b0, 1'b0, '0);
    bus.chk_src1_idx = 5'd5;
    sample();
    chk("raw_dep_set", 32'(bus.chk_src1_dep), 32'd1);
    advance();
    set_lp(1'b1, 1'b1, 5'd5, 32'hDEADBEEF);
    sample();
    chk("lp_rf_wen",  32'(bus.rf_wen), 32'd1);
    chk("lp_rf_widx", 32'(bus.rf_widx), 32'd5);
    chk("lp_rf_wdat", bus.rf_wdat, 32'hDEADBEEF);
    advance();
    set_lp(1'b0, 1'b0, '0, '0);
    sample();
    chk("raw_dep_clr", 32'(bus.chk_src1_dep), 32'd0);
    chk("lp_oitf_empty", 32'(bus.oitf_empty), 32'd1);
    advance();
    idle();

    // Streaming long pipe against a waiting ALU.
    drive(0, 0, 100, 100);
    sample(); advance();
    for (int k = 0; k < 10; k++) begin
      drive(100, 100, 100, 100);
      sample();
      chk("starve_pattern", 32'(bus.alu_wbck_ready), 32'(k % 5 == 4));
      advance();
    end
    drain();

    // Outstanding limit and simultaneous dispatch/completion.
    set_disp(1'b1, 1'b1, 5'd11); sample(); advance();
    set_disp(1'b1, 1'b1, 5'd12); sample(); advance();
    set_disp(1'b1, 1'b1, 5'd13);
    sample();
    chk("full_not_ready", 32'(bus.disp_longp_ready), 32'd0);
    advance();
    set_lp(1'b1, 1'b1, 5'd11, $urandom());
    sample();
    chk("full_still_held", 32'(bus.disp_longp_ready), 32'd0);
    advance();
    set_lp(1'b1, 1'b1, 5'd12, $urandom());
    sample();
    chk("ready_after_cmpl", 32'(bus.disp_longp_ready), 32'd1);
    advance();
    set_disp(1'b0, 1'b0, '0);
    set_lp(1'b0, 1'b0, '0, '0);
    sample();
    chk("cnt_unchanged_ready", 32'(bus.disp_longp_ready), 32'd1);
    chk("cnt_unchanged_busy",  32'(bus.oitf_empty), 32'd0);
    advance();

    // Same index cleared and re-set in one cycle stays pending.
    set_lp(1'b1, 1'b1, 5'd13, $urandom());
    set_disp(1'b1, 1'b1, 5'd7);
    sample(); advance();
    set_lp(1'b1, 1'b1, 5'd7, $urandom());
    set_disp(1'b1, 1'b1, 5'd7);
    bus.chk_dest_idx = 5'd7;
    sample(); advance();
    set_lp(1'b0, 1'b0, '0, '0);
    set_disp(1'b0, 1'b0, '0);
    sample();
    chk("same_idx_waw", 32'(bus.chk_waw_dep), 32'd1);
    advance();
    set_alu(1'b1, 5'd0, 32'h1234_5678);
    sample();
    chk("x0_alu_ready", 32'(bus.alu_wbck_ready), 32'd1);
    chk("x0_rf_wen",    32'(bus.rf_wen), 32'd0);
    advance();
    set_alu(1'b0, '0, '0);

    // Completion-only long-pipe op alongside an ALU write.
    set_disp(1'b1, 1'b0, 5'd3); sample(); advance();
    set_disp(1'b0, 1'b0, '0);
    set_lp(1'b1, 1'b1, 5'd7, $urandom()); sample(); advance();
    set_lp(1'b1, 1'b0, 5'd3, $urandom());
    set_alu(1'b1, 5'd9, 32'hCAFE_0009);
    sample();
    chk("nowen_alu_ready", 32'(bus.alu_wbck_ready), 32'd1);
    chk("nowen_lp_ready",  32'(bus.longp_wbck_ready), 32'd1);
    chk("nowen_rf_widx",   32'(bus.rf_widx), 32'd9);
    advance();
    idle();
    sample();
    chk("nowen_oitf_empty", 32'(bus.oitf_empty), 32'd1);
    advance();

    // Random traffic with a mid-run reset that flushes every requester.
    for (int i = 0; i < 300; i++) begin
      if (i == 150) begin
        idle();
        rst_n = 1'b0;
        sample(); advance();
        rst_n = 1'b1;
      end
      drive(60, 50, 50, 70);
      sample();
      advance();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
